int_flag_ctrl: RTL and testbench
================================

INT_FLAG_CTRL -- requirements
Module: int_flag_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4, number of interrupt sources; index 0 is the highest priority.
REQ-002 SHALL have parameter DEPTH, default 4, maximum nesting depth of the flag save stack.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port clk_en, input, 1 bit: cycle qualifier; when 0, all state holds and all pulse outputs are 0.
REQ-006 SHALL have port irq_i, input, NSRC bits: level interrupt requests.
REQ-007 SHALL have port irq_en_i, input, NSRC bits: per-source enable mask.
REQ-008 SHALL have port gie_i, input, 1 bit: global interrupt enable.
REQ-009 SHALL have port bnd_i, input, 1 bit: the CPU is at an instruction boundary.
REQ-010 SHALL have port c_i, z_i, inputs, 1 bit each: current carry and zero flags from the flag register.
REQ-011 SHALL have port reti_i, input, 1 bit: return-from-interrupt pulse.
REQ-012 SHALL have port int_ack_i, input, 1 bit: the CPU accepts the pending interrupt.
REQ-013 SHALL have port int_req_o, output, 1 bit: interrupt pending to the CPU.
REQ-014 SHALL have port int_vec_o, output, $clog2(NSRC) bits: source id of the pending interrupt.
REQ-015 SHALL have port irq_clr_o, output, NSRC bits: one-hot, single-cycle acknowledge to the serviced source.
REQ-016 SHALL have port iwe_o, intc_o, intz_o, outputs, 1 bit each: restore write-enable and the restored flags, driving the flag register's interrupt write port.
REQ-017 SHALL have port depth_o, output, $clog2(DEPTH+1) bits: current nesting depth.
REQ-018 SHALL have port err_o, output, 1 bit: sticky error flag.

Function
REQ-019 SHALL implement the FSM states IDLE, REQ, SAVE and RESTORE; all transitions occur only on cycles where clk_en=1.
REQ-020 SHALL treat source i as eligible when irq_i[i] & irq_en_i[i] & gie_i is true, i is lower than the in-service id at the stack top (or the stack is empty), and depth < DEPTH.
REQ-021 SHALL move IDLE->REQ when bnd_i=1, reti_i=0 and any source is eligible, latching the lowest eligible index into int_vec_o.
REQ-022 SHALL hold int_req_o=1 and int_vec_o stable throughout REQ, even if irq_i deasserts.
REQ-023 SHALL move REQ->SAVE on int_ack_i=1, then SAVE->IDLE on the following cycle.
REQ-024 In SAVE, SHALL push {c_i, z_i, int_vec_o} onto the stack, increment depth, and assert irq_clr_o[int_vec_o] for exactly one cycle.
REQ-025 SHALL move IDLE->RESTORE when reti_i=1 and depth>0, then RESTORE->IDLE on the following cycle.
REQ-026 In RESTORE, SHALL assert iwe_o=1 for one cycle with intc_o/intz_o equal to the top entry, pop that entry, and decrement depth.
REQ-027 Latency SHALL be: request-to-int_req_o 1 cycle, ack-to-irq_clr_o 1 cycle, reti_i-to-iwe_o 1 cycle.
REQ-028 If reti_i and an eligible request occur together in IDLE, reti_i SHALL win; the request is re-evaluated once the FSM is back in IDLE.
REQ-029 reti_i with depth=0 SHALL set err_o and otherwise be ignored.
REQ-030 reti_i in REQ or SAVE SHALL set err_o and otherwise be ignored.
REQ-031 When depth=DEPTH, SHALL raise no request; err_o is not set in this case.
REQ-032 iwe_o, intc_o, intz_o and irq_clr_o SHALL be 0 outside their respective states; int_req_o SHALL be 0 outside REQ.

Reset
REQ-033 While rst=0, SHALL immediately force: FSM=IDLE, depth=0, err_o=0, int_req_o=0, int_vec_o=0, irq_clr_o=0, iwe_o=0, intc_o=0, intz_o=0, and stack contents cleared.
REQ-034 Reset mid-sequence (REQ, SAVE or RESTORE) SHALL abandon the sequence with no pulse emitted; operation resumes on the first clock edge after rst returns to 1.

Verification
REQ-035 irq_i=0100, irq_en_i=1111, gie_i=1, bnd_i=1, c_i=1, z_i=0, ack 2 cycles later -> int_req_o=1 and int_vec_o=2 on the next cycle; irq_clr_o=0100 one cycle after ack; depth_o=1.
REQ-036 Continuing REQ-035, source 0 fires -> nests, depth_o=2; source 3 fires -> no request. Two reti_i pulses -> iwe_o pulses; the second restores intc_o=1, intz_o=0; depth_o=0.
REQ-037 irq_i=0011 simultaneously -> int_vec_o=0; irq_i deasserted during REQ -> int_req_o stays 1 until ack.
REQ-038 reti_i with depth_o=0 -> err_o=1 and sticky, no iwe_o; reti_i coincident with a request in IDLE -> RESTORE first, REQ after.
REQ-039 Fill to depth 4 -> a further eligible irq raises no int_req_o; rst=0 during SAVE -> all outputs 0 immediately, depth_o=0.
REQ-040 clk_en=0 held during REQ with ack asserted -> no state change and no irq_clr_o until clk_en=1.

Source files
------------

// File: rtl/int_flag_ctrl.sv
// Interrupt priority controller with a nested save/restore stack for the
// carry/zero flags; one request in flight, nesting only for higher priority.
module int_flag_ctrl #(
  parameter int NSRC  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic [NSRC-1:0]            irq_i,
  input  logic [NSRC-1:0]            irq_en_i,
  input  logic                       gie_i,
  input  logic                       bnd_i,
  input  logic                       c_i,
  input  logic                       z_i,
  input  logic                       reti_i,
  input  logic                       int_ack_i,
  output logic                       int_req_o,
  output logic [$clog2(NSRC)-1:0]    int_vec_o,
  output logic [NSRC-1:0]            irq_clr_o,
  output logic                       iwe_o,
  output logic                       intc_o,
  output logic                       intz_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o,
  output logic                       err_o
);

  localparam int IW = $clog2(NSRC);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, SAVE, RESTORE} state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [DW-1:0]   r_depth;
  logic            r_err;
  logic [IW-1:0]   r_vec;
  logic            r_stk_c  [DEPTH];
  logic            r_stk_z  [DEPTH];
  logic [IW-1:0]   r_stk_id [DEPTH];

  logic [AW-1:0]   w_top;
  logic [AW-1:0]   w_push;
  logic [IW-1:0]   w_top_id;
  logic [NSRC-1:0] w_elig;
  logic [IW-1:0]   w_sel;
  logic            w_any;
  logic            w_latch;
  logic            w_err_set;

  assign w_top    = AW'(r_depth - DW'(1));
  assign w_push   = AW'(r_depth);
  assign w_top_id = r_stk_id[w_top];

  // Only strictly higher-priority sources may preempt the one in service.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_elig[i] = irq_i[i] & irq_en_i[i] & gie_i
                & ((r_depth == '0) || (IW'(i) < w_top_id))
                & (r_depth < DMAX);
    end
  end

  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel = IW'(i);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_latch   = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (reti_i) begin
          if (r_depth != '0) w_nxt = RESTORE;
          else               w_err_set = 1'b1;
        end else if (bnd_i && w_any) begin
          w_nxt   = REQ;
          w_latch = 1'b1;
        end
      end
      REQ: begin
        w_err_set = reti_i;
        if (int_ack_i) w_nxt = SAVE;
      end
      SAVE: begin
        w_err_set = reti_i;
        w_nxt     = IDLE;
      end
      RESTORE: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_depth <= '0;
      r_err   <= 1'b0;
      r_vec   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_stk_c[k]  <= 1'b0;
        r_stk_z[k]  <= 1'b0;
        r_stk_id[k] <= '0;
      end
    end else if (clk_en) begin
      r_state <= w_nxt;
      if (w_latch)   r_vec <= w_sel;
      if (w_err_set) r_err <= 1'b1;
      if (r_state == SAVE) begin
        r_stk_c[w_push]  <= c_i;
        r_stk_z[w_push]  <= z_i;
        r_stk_id[w_push] <= r_vec;
        r_depth          <= r_depth + DW'(1);
      end else if (r_state == RESTORE) begin
        r_depth <= r_depth - DW'(1);
      end
    end
  end

  // Pulses are qualified by clk_en so a stalled cycle emits nothing.
  assign int_req_o = (r_state == REQ);
  assign int_vec_o = r_vec;
  assign irq_clr_o = ((r_state == SAVE) && clk_en) ? (NSRC'(1) << r_vec) : '0;
  assign iwe_o     = (r_state == RESTORE) && clk_en;
  assign intc_o    = iwe_o & r_stk_c[w_top];
  assign intz_o    = iwe_o & r_stk_z[w_top];
  assign depth_o   = r_depth;
  assign err_o     = r_err;

endmodule

// File: tb/tb_int_flag_ctrl.sv
// Bench for int_flag_ctrl: directed scenarios then random traffic, all
// compared each cycle against a queue-based model of the interrupt rules.
module tb_int_flag_ctrl;
  localparam int NSRC  = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, clk_en, gie_i, bnd_i, c_i, z_i, reti_i, int_ack_i;
  logic [NSRC-1:0] irq_i, irq_en_i;
  logic int_req_o, iwe_o, intc_o, intz_o, err_o;
  logic [2:0] int_vec_o;
  logic [NSRC-1:0] irq_clr_o;
  logic [2:0] depth_o;

  int checks = 0;
  int errors = 0;

  int_flag_ctrl #(.NSRC(NSRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .gie_i(gie_i), .bnd_i(bnd_i), .c_i(c_i), .z_i(z_i), .reti_i(reti_i),
    .int_ack_i(int_ack_i), .int_req_o(int_req_o), .int_vec_o(int_vec_o),
    .irq_clr_o(irq_clr_o), .iwe_o(iwe_o), .intc_o(intc_o), .intz_o(intz_o),
    .depth_o(depth_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { bit c; bit z; int id; } entry_t;
  entry_t stk[$];
  int m_pend;   // source awaiting ack, -1 if none
  int m_clr;    // source being acknowledged this cycle, -1 if none
  bit m_pop;    // flags being restored this cycle
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_pend = -1;
    m_clr  = -1;
    m_pop  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_update();
    entry_t e;
    int best;
    if (m_pop) begin
      void'(stk.pop_back());
      m_pop = 1'b0;
    end else if (m_clr >= 0) begin
      if (reti_i) m_err = 1'b1;
      e.c = c_i; e.z = z_i; e.id = m_clr;
      stk.push_back(e);
      m_clr = -1;
    end else if (m_pend >= 0) begin
      if (reti_i) m_err = 1'b1;
      if (int_ack_i) begin
        m_clr  = m_pend;
        m_pend = -1;
      end
    end else if (reti_i) begin
      if (stk.size() > 0) m_pop = 1'b1;
      else                m_err = 1'b1;
    end else if (bnd_i) begin
      best = -1;
      for (int i = NSRC - 1; i >= 0; i--)
        if (irq_i[i] && irq_en_i[i] && gie_i && stk.size() < DEPTH &&
            (stk.size() == 0 || i < stk[$].id))
          best = i;
      m_pend = best;
    end
  endtask

  task automatic step();
    logic [NSRC-1:0] exp_clr;
    bit exp_iwe;
    #1;
    if (!rst) model_reset();
    exp_clr = (m_clr >= 0 && clk_en) ? (NSRC'(1) << m_clr) : '0;
    exp_iwe = m_pop && clk_en;
    chk("req", 32'(int_req_o), 32'(m_pend >= 0));
    if (m_pend >= 0) chk("vec", 32'(int_vec_o), 32'(m_pend));
    chk("clr", 32'(irq_clr_o), 32'(exp_clr));
    chk("iwe", 32'(iwe_o), 32'(exp_iwe));
    chk("intc", 32'(intc_o), 32'(exp_iwe ? stk[$].c : 1'b0));
    chk("intz", 32'(intz_o), 32'(exp_iwe ? stk[$].z : 1'b0));
    chk("depth", 32'(depth_o), 32'(stk.size()));
    chk("err", 32'(err_o), 32'(m_err));
    @(posedge clk);
    if (rst && clk_en) model_update();
    @(negedge clk);
  endtask

  task automatic take(input logic [NSRC-1:0] irq);
    irq_i = irq; step();
    int_ack_i = 1'b1; step();
    int_ack_i = 1'b0; irq_i = '0; step();
  endtask

  initial begin
    model_reset();
    rst = 1'b0; clk_en = 1'b1; irq_i = '0; irq_en_i = '1; gie_i = 1'b1;
    bnd_i = 1'b1; c_i = 1'b1; z_i = 1'b0; reti_i = 1'b0; int_ack_i = 1'b0;
    @(negedge clk);
    step();
    chk("rst_req", 32'(int_req_o), 0);
    chk("rst_vec", 32'(int_vec_o), 0);
    chk("rst_depth", 32'(depth_o), 0);
    rst = 1'b1;

    // Single request from source 2, ack two cycles after the request.
    irq_i = 8'h04; step();
    chk("r35_req", 32'(int_req_o), 1);
    chk("r35_vec", 32'(int_vec_o), 2);
    step();
    int_ack_i = 1'b1; step();
    chk("r35_clr", 32'(irq_clr_o), 32'h04);
    int_ack_i = 1'b0; step();
    chk("r35_depth", 32'(depth_o), 1);

    // Nest source 0, then source 3 must be blocked by priority.
    irq_i = 8'h05; step();
    chk("r36_vec0", 32'(int_vec_o), 0);
    c_i = 1'b0; z_i = 1'b1; int_ack_i = 1'b1; step();
    int_ack_i = 1'b0; c_i = 1'b1; z_i = 1'b0; step();
    chk("r36_depth2", 32'(depth_o), 2);
    irq_i = 8'h0D; step(); step();
    chk("r36_noreq3", 32'(int_req_o), 0);
    irq_i = '0; reti_i = 1'b1; step();
    chk("r36_iwe1", 32'(iwe_o), 1);
    reti_i = 1'b0; step();
    reti_i = 1'b1; step();
    chk("r36_iwe2", 32'(iwe_o), 1);
    chk("r36_intc", 32'(intc_o), 1);
    chk("r36_intz", 32'(intz_o), 0);
    reti_i = 1'b0; step();
    chk("r36_depth0", 32'(depth_o), 0);

    // Simultaneous sources, then request held after irq drops.
    irq_i = 8'h03; step();
    chk("r37_vec", 32'(int_vec_o), 0);
    irq_i = '0; step(); step();
    chk("r37_hold", 32'(int_req_o), 1);
    int_ack_i = 1'b1; step();
    int_ack_i = 1'b0; step();
    reti_i = 1'b1; step();
    reti_i = 1'b0; step();

    // Underflow sets a sticky error; reti beats a coincident request.
    reti_i = 1'b1; step();
    chk("r38_err", 32'(err_o), 1);
    chk("r38_noiwe", 32'(iwe_o), 0);
    reti_i = 1'b0; step();
    chk("r38_sticky", 32'(err_o), 1);
    take(8'h04);
    irq_i = 8'h02; reti_i = 1'b1; step();
    chk("r38_restore", 32'(iwe_o), 1);
    chk("r38_noreq", 32'(int_req_o), 0);
    reti_i = 1'b0; step(); step();
    chk("r38_req_after", 32'(int_req_o), 1);
    chk("r38_vec_after", 32'(int_vec_o), 1);
    int_ack_i = 1'b1; step();
    int_ack_i = 1'b0; irq_i = '0; step();
    reti_i = 1'b1; step();
    reti_i = 1'b0; step();

    // Fill the stack, then an otherwise eligible source is refused.
    take(8'h80); take(8'h40); take(8'h20); take(8'h10);
    chk("r39_full", 32'(depth_o), 4);
    irq_i = 8'h08; step(); step();
    chk("r39_noreq", 32'(int_req_o), 0);
    chk("r39_noerr", 32'(err_o), 1);
    irq_i = '0; reti_i = 1'b1; step();
    reti_i = 1'b0; step();
    irq_i = 8'h08; step();
    int_ack_i = 1'b1; step();
    rst = 1'b0; #1;
    chk("r39_rst_clr", 32'(irq_clr_o), 0);
    chk("r39_rst_depth", 32'(depth_o), 0);
    chk("r39_rst_err", 32'(err_o), 0);
    step();
    rst = 1'b1; int_ack_i = 1'b0; irq_i = '0; step();

    // Stalled clock enable freezes a pending acknowledge.
    irq_i = 8'h04; step();
    clk_en = 1'b0; int_ack_i = 1'b1; step(); step();
    chk("r40_hold_req", 32'(int_req_o), 1);
    chk("r40_no_clr", 32'(irq_clr_o), 0);
    clk_en = 1'b1; step();
    chk("r40_clr", 32'(irq_clr_o), 32'h04);
    int_ack_i = 1'b0; irq_i = '0; step();

    for (int n = 0; n < 3000; n++) begin
      irq_i     = NSRC'($urandom);
      irq_en_i  = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '1;
      gie_i     = ($urandom_range(0, 9) != 0);
      bnd_i     = $urandom_range(0, 1);
      c_i       = $urandom_range(0, 1);
      z_i       = $urandom_range(0, 1);
      reti_i    = ($urandom_range(0, 5) == 0);
      int_ack_i = ($urandom_range(0, 2) == 0);
      clk_en    = ($urandom_range(0, 6) != 0);
      rst       = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
